// File: rtl/kv_lut_builder.sv
// Sequential writer for the packed key/data lookup table driven onto `lut`; scans slots one per cycle.
// Optional KV_LUT_CNT_EN adds a registered live-entry count output `entry_count`.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_SCAN   | examining slot r_idx for a key match / lowest free slot
// S_COMMIT | applying the latched operation to the table
// S_RESP   | presenting the response until rsp_ready
module kv_lut_builder #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [1:0]                                   cmd_op,
    input  logic [KEY_LEN-1:0]                           cmd_key,
    input  logic [DATA_LEN-1:0]                          cmd_data,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [1:0]                                   rsp_status,
    output logic [(($clog2(NR_KEY) > 1) ? $clog2(NR_KEY) : 1)-1:0] rsp_index,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]         lut,
    output logic [NR_KEY-1:0]                            entry_valid
`ifdef KV_LUT_CNT_EN
    ,
    output logic [$clog2(NR_KEY+1)-1:0]                  entry_count
`endif
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int IDX_W    = ($clog2(NR_KEY) > 1) ? $clog2(NR_KEY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    localparam logic [1:0] ST_NEW  = 2'b00;
    localparam logic [1:0] ST_UPD  = 2'b01;
    localparam logic [1:0] ST_DEL  = 2'b10;
    localparam logic [1:0] ST_FAIL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_op;
    logic [KEY_LEN-1:0]    r_key;
    logic [DATA_LEN-1:0]   r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_match;
    logic [IDX_W-1:0]      r_match_idx;
    logic                  r_free;
    logic [IDX_W-1:0]      r_free_idx;
    logic [1:0]            r_status;
    logic [IDX_W-1:0]      r_index;

    logic [KEY_LEN-1:0]    r_keys  [NR_KEY];
    logic [DATA_LEN-1:0]   r_datas [NR_KEY];
    logic [NR_KEY-1:0]     r_valid;

    logic                  w_hit;
    logic                  w_last;
    logic [1:0]            w_status;
    logic [IDX_W-1:0]      w_slot;
    logic                  w_store;
    logic                  w_new;
    logic                  w_del;
    logic                  w_clear;
    logic [NR_KEY*PAIR_LEN-1:0] w_lut;

    assign w_hit  = r_valid[r_idx] && (r_keys[r_idx] == r_key);
    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE, OP_DELETE: w_state_nxt = S_SCAN;
                        OP_CLEAR:            w_state_nxt = S_COMMIT;
                        default:             w_state_nxt = S_RESP;
                    endcase
                end
            end
            S_SCAN: begin
                if (w_hit || w_last) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A recorded match always wins over a free slot, so duplicate keys cannot arise.
    always_comb begin
        w_status = ST_FAIL;
        w_slot   = '0;
        w_store  = 1'b0;
        w_new    = 1'b0;
        w_del    = 1'b0;
        w_clear  = 1'b0;
        case (r_op)
            OP_WRITE: begin
                if (r_match) begin
                    w_status = ST_UPD;
                    w_slot   = r_match_idx;
                    w_store  = 1'b1;
                end else if (r_free) begin
                    w_status = ST_NEW;
                    w_slot   = r_free_idx;
                    w_store  = 1'b1;
                    w_new    = 1'b1;
                end
            end
            OP_DELETE: begin
                if (r_match) begin
                    w_status = ST_DEL;
                    w_slot   = r_match_idx;
                    w_del    = 1'b1;
                end
            end
            OP_CLEAR: begin
                w_status = ST_DEL;
                w_clear  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_key       <= '0;
            r_data      <= '0;
            r_idx       <= '0;
            r_match     <= 1'b0;
            r_match_idx <= '0;
            r_free      <= 1'b0;
            r_free_idx  <= '0;
            r_status    <= '0;
            r_index     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_key       <= cmd_key;
                        r_data      <= cmd_data;
                        r_idx       <= '0;
                        r_match     <= 1'b0;
                        r_match_idx <= '0;
                        r_free      <= 1'b0;
                        r_free_idx  <= '0;
                        if (cmd_op == 2'b11) begin
                            r_status <= ST_FAIL;
                            r_index  <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_match     <= 1'b1;
                        r_match_idx <= r_idx;
                    end else if (!r_valid[r_idx] && !r_free) begin
                        r_free     <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    if (!w_hit && !w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_status <= w_status;
                    r_index  <= w_slot;
                end
                default: ;
            endcase
        end
    end

    // Table storage: only reset or the COMMIT state may touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int n = 0; n < NR_KEY; n++) begin
                r_keys[n]  <= '0;
                r_datas[n] <= '0;
            end
        end else if (r_state == S_COMMIT) begin
            if (w_clear) begin
                r_valid <= '0;
                for (int n = 0; n < NR_KEY; n++) begin
                    r_keys[n]  <= '0;
                    r_datas[n] <= '0;
                end
            end else if (w_store) begin
                r_keys[w_slot]  <= r_key;
                r_datas[w_slot] <= r_data;
                r_valid[w_slot] <= 1'b1;
            end else if (w_del) begin
                r_keys[w_slot]  <= '0;
                r_datas[w_slot] <= '0;
                r_valid[w_slot] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_lut = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            w_lut[n*PAIR_LEN +: PAIR_LEN] = r_valid[n] ? {r_keys[n], r_datas[n]} : '0;
        end
    end

`ifdef KV_LUT_CNT_EN
    localparam int CNT_W = $clog2(NR_KEY + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == S_COMMIT) begin
            if (w_clear) begin
                r_count <= '0;
            end else if (w_new) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_del) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign entry_count = r_count;
`endif

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_status  = r_status;
    assign rsp_index   = r_index;
    assign lut         = w_lut;
    assign entry_valid = r_valid;

endmodule

// File: tb/tb_kv_lut_builder.sv
// Scoreboard bench for kv_lut_builder: slot-array reference model, directed table scenarios, then random commands.
module tb_kv_lut_builder;

    localparam int NR = 4;
    localparam int PL = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_key = 4'h0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [1:0]  rsp_index;
    logic [47:0] lut;
    logic [3:0]  entry_valid;
`ifdef KV_LUT_CNT_EN
    logic [2:0]  entry_count;
`endif

    kv_lut_builder #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_key     (cmd_key),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_index   (rsp_index),
        .lut         (lut),
        .entry_valid (entry_valid)
`ifdef KV_LUT_CNT_EN
        ,
        .entry_count (entry_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  idx;
        logic [47:0] lut;
        logic [3:0]  ev;
        int          cnt;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  m_key  [NR];
    logic [7:0]  m_data [NR];
    logic        m_vld  [NR];
    logic [47:0] c_lut = '0;
    logic [3:0]  c_ev = '0;
    int          c_cnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    bit          hold = 1'b0;
    bit          seen = 1'b0;

    function automatic void cmp(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_key[i]  = '0;
            m_data[i] = '0;
            m_vld[i]  = 1'b0;
        end
    endfunction

    // Responses pop only on handshake; every cycle in between re-checks the held fields.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    cmp("rsp_unexpected", 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        cmp("rsp_latency", cyc, q[0].due);
                    end
                    cmp("rsp_status", rsp_status, q[0].st);
                    cmp("rsp_index", rsp_index, q[0].idx);
                    cmp("rsp_lut", lut, q[0].lut);
                    cmp("rsp_entry_valid", entry_valid, q[0].ev);
                    cmp("rsp_cmd_ready", cmd_ready, 0);
`ifdef KV_LUT_CNT_EN
                    cmp("rsp_entry_count", entry_count, q[0].cnt);
`endif
                    if (rsp_ready) begin
                        c_lut = q[0].lut;
                        c_ev  = q[0].ev;
                        c_cnt = q[0].cnt;
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                cmp("idle_lut", lut, c_lut);
                cmp("idle_entry_valid", entry_valid, c_ev);
                cmp("idle_cmd_ready", cmd_ready, (q.size() == 0));
`ifdef KV_LUT_CNT_EN
                cmp("idle_entry_count", entry_count, c_cnt);
`endif
                if (q.size() > 0 && cyc >= q[0].due) begin
                    cmp("rsp_late", 1, 0);
                    c_lut = q[0].lut;
                    c_ev  = q[0].ev;
                    c_cnt = q[0].cnt;
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] k, input logic [7:0] d);
        int   t;
        int   hit;
        int   fr;
        int   lat;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            cmp("cmd_ready_timeout", 0, 1);
            return;
        end
        hit = -1;
        for (int i = 0; i < NR; i++) if (m_vld[i] && m_key[i] == k) hit = i;
        fr = -1;
        for (int i = NR - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
        e.st  = 2'b11;
        e.idx = 2'd0;
        lat   = NR + 1;
        case (op)
            2'b00: begin
                if (hit >= 0) begin
                    m_data[hit] = d;
                    e.st = 2'b01; e.idx = 2'(hit); lat = hit + 2;
                end else if (fr >= 0) begin
                    m_key[fr] = k; m_data[fr] = d; m_vld[fr] = 1'b1;
                    e.st = 2'b00; e.idx = 2'(fr);
                end
            end
            2'b01: begin
                if (hit >= 0) begin
                    m_key[hit] = '0; m_data[hit] = '0; m_vld[hit] = 1'b0;
                    e.st = 2'b10; e.idx = 2'(hit); lat = hit + 2;
                end
            end
            2'b10: begin
                model_clear();
                e.st = 2'b10; lat = 1;
            end
            default: lat = 0;
        endcase
        e.lut = '0;
        e.ev  = '0;
        e.cnt = 0;
        for (int i = 0; i < NR; i++) begin
            if (m_vld[i]) begin
                e.lut[i*PL +: PL] = {m_key[i], m_data[i]};
                e.ev[i] = 1'b1;
                e.cnt++;
            end
        end
        e.due = cyc + 1 + lat;
        #1;
        q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = k;
        cmd_data  = d;
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || !cmd_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || !cmd_ready) cmp("idle_timeout", 0, 1);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        chk_en    = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        seen = 1'b0;
        model_clear();
        c_lut = '0;
        c_ev  = '0;
        c_cnt = 0;
        cmp("reset_cmd_ready", cmd_ready, 1);
        cmp("reset_rsp_valid", rsp_valid, 0);
        cmp("reset_lut", lut, 0);
        cmp("reset_entry_valid", entry_valid, 0);
`ifdef KV_LUT_CNT_EN
        cmp("reset_entry_count", entry_count, 0);
`endif
        chk_en = 1'b1;
    endtask

    initial begin
        int r;
        model_clear();
        do_reset(2);

        send(2'b00, 4'h3, 8'hA5);
        wait_idle();
        cmp("t2_lut0", lut[11:0], 12'h3A5);
        cmp("t2_ev", entry_valid, 4'b0001);

        send(2'b00, 4'h3, 8'h5A);
        wait_idle();
        cmp("t3_lut0", lut[11:0], 12'h35A);
        cmp("t3_upper", lut[47:12], 0);

        send(2'b10, 4'h0, 8'h00);
        for (int i = 1; i <= 4; i++) send(2'b00, 4'(i), 8'(8'h10 + i));
        send(2'b00, 4'h7, 8'hEE);
        wait_idle();
        cmp("t4_ev_full", entry_valid, 4'b1111);
`ifdef KV_LUT_CNT_EN
        cmp("t4_count", entry_count, 4);
`endif

        send(2'b01, 4'h1, 8'h00);
        wait_idle();
        cmp("t5_ev", entry_valid, 4'b1110);
        cmp("t5_lut0", lut[11:0], 12'h000);
        send(2'b01, 4'h1, 8'h00);
        send(2'b00, 4'h9, 8'h11);
        wait_idle();
        cmp("t5_lut0_new", lut[11:0], 12'h911);

        hold = 1'b1;
        send(2'b10, 4'h0, 8'h00);
        repeat (6) begin
            @(negedge clk);
            #1;
            cmp("t6_hold_valid", rsp_valid, 1);
            cmp("t6_hold_lut", lut, 0);
        end
        hold = 1'b0;
        send(2'b11, 4'h5, 8'h55);
        wait_idle();

        send(2'b00, 4'h1, 8'h21);
        send(2'b00, 4'h2, 8'h22);
        send(2'b00, 4'h3, 8'h23);
        send(2'b00, 4'h6, 8'h26);
        @(negedge clk);
        do_reset(2);
        repeat (12) @(negedge clk);
        #1;
        cmp("t1_scan_reset_lut", lut, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r < 10 || r == 19) send(2'b00, 4'($urandom_range(0, 5)), 8'($urandom));
            else if (r < 17)       send(2'b01, 4'($urandom_range(0, 5)), 8'($urandom));
            else if (r == 17)      send(2'b10, 4'($urandom), 8'($urandom));
            else                   send(2'b11, 4'($urandom), 8'($urandom));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
